// File: rtl/pht_update_queue.sv
// pht_update_queue: buffers gshare PHT counter updates between branch
// resolution and the PHT write port.
//
// Each accepted conditional-branch result becomes a 2-bit saturating-counter
// update at index (PC word bits ^ global history). Updates sit in a circular
// FIFO and drain one per cycle while the fetch stage grants the write port.
// An update to the same index as the tail entry overwrites the tail value
// instead of taking a new slot. Updates that find the queue full are dropped
// and counted.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   upd_*                resolved branch result (valid, conditional flag,
//                        branch address, direction, history, prior counter)
//   pht_wr_grant         PHT write port free this cycle
//   pht_we/pht_wa/pht_wv PHT write enable/address/value (head entry)
//   q_count              current occupancy
//   q_full, q_empty      occupancy == QUEUE_SIZE / occupancy == 0
//   drop_count           saturating count of updates lost to overflow
module pht_update_queue #(
  parameter int unsigned QUEUE_SIZE          = 32,
  parameter int unsigned PHT_INDEX_WIDTH     = 10,
  parameter int unsigned GHR_WIDTH           = 10,
  parameter int unsigned PC_WIDTH            = 32,
  parameter int unsigned INSN_ADDR_BIT_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         upd_valid,
  input  logic                         upd_is_cond_br,
  input  logic [PC_WIDTH-1:0]          upd_br_addr,
  input  logic                         upd_exec_taken,
  input  logic [GHR_WIDTH-1:0]         upd_global_history,
  input  logic [1:0]                   upd_pht_prev,
  input  logic                         pht_wr_grant,
  output logic                         pht_we,
  output logic [PHT_INDEX_WIDTH-1:0]   pht_wa,
  output logic [1:0]                   pht_wv,
  output logic [$clog2(QUEUE_SIZE):0]  q_count,
  output logic                         q_full,
  output logic                         q_empty,
  output logic [15:0]                  drop_count
);

  localparam int unsigned PTR_W  = $clog2(QUEUE_SIZE);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DROP_W = 16;
  localparam int unsigned IDX_LO = INSN_ADDR_BIT_WIDTH;
  localparam int unsigned IDX_HI = PHT_INDEX_WIDTH + INSN_ADDR_BIT_WIDTH - 1;

  // Entry storage is deliberately not reset; only pointers/count define validity.
  logic [PHT_INDEX_WIDTH-1:0] idx_mem [QUEUE_SIZE];
  logic [1:0]                 val_mem [QUEUE_SIZE];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic                       acc;
  logic                       merge;
  logic                       enq;
  logic                       drop;
  logic [PTR_W-1:0]           tail_last;
  logic [PHT_INDEX_WIDTH-1:0] new_idx;
  logic [1:0]                 new_val;

  // PC bits outside the index field carry no information for the PHT.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{upd_br_addr[PC_WIDTH-1:IDX_HI+1], upd_br_addr[IDX_LO-1:0]};

  // Update decode, dequeue, merge/enqueue/drop decisions and next state.
  always_comb begin
    acc       = upd_valid & upd_is_cond_br;
    new_idx   = upd_br_addr[IDX_HI:IDX_LO] ^ PHT_INDEX_WIDTH'(upd_global_history);
    new_val   = upd_pht_prev;
    if (upd_exec_taken && upd_pht_prev != 2'd3) begin
      new_val = upd_pht_prev + 2'd1;
    end else if (!upd_exec_taken && upd_pht_prev != 2'd0) begin
      new_val = upd_pht_prev - 2'd1;
    end

    q_empty   = (count_q == CNT_W'(0));
    q_full    = (count_q == CNT_W'(QUEUE_SIZE));
    pht_we    = !q_empty && pht_wr_grant;
    pht_wa    = idx_mem[head_q];
    pht_wv    = val_mem[head_q];

    tail_last = tail_q - PTR_W'(1);
    // A lone entry leaving this cycle can no longer absorb the update.
    merge     = acc && !q_empty && (idx_mem[tail_last] == new_idx)
                && !((count_q == CNT_W'(1)) && pht_we);
    enq       = acc && !merge && (!q_full || pht_we);
    drop      = acc && !merge && q_full && !pht_we;

    head_d    = pht_we ? head_q + PTR_W'(1) : head_q;
    tail_d    = enq ? tail_q + PTR_W'(1) : tail_q;
    count_d   = count_q + CNT_W'(enq) - CNT_W'(pht_we);
    drop_d    = (drop && drop_q != {DROP_W{1'b1}}) ? drop_q + DROP_W'(1) : drop_q;

    q_count    = count_q;
    drop_count = drop_q;
  end

  // Pointer, occupancy and drop counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // Queue storage: new entry at the tail, or in-place value rewrite on merge.
  always_ff @(posedge clk) begin
    if (enq) begin
      idx_mem[tail_q] <= new_idx;
      val_mem[tail_q] <= new_val;
    end else if (merge) begin
      val_mem[tail_last] <= new_val;
    end
  end

endmodule

// File: doc/pht_update_queue.md
Name: pht_update_queue

Overview:
- Sits downstream of branch resolution and upstream of the gshare PHT write port.
- Turns each resolved conditional-branch result into a 2-bit saturating-counter update at index (PC word bits XOR global history).
- Buffers updates in a circular FIFO and drains one per cycle whenever the fetch stage grants the PHT write port.
- Merges a new update into the tail entry when both target the same index, and counts updates dropped on overflow.

Parameters:
- QUEUE_SIZE, 32, FIFO depth; power of two, at least 2.
- PHT_INDEX_WIDTH, 10, PHT index width (1024 entries).
- GHR_WIDTH, 10, global history width; must be no wider than PHT_INDEX_WIDTH.
- PC_WIDTH, 32, PC width.
- INSN_ADDR_BIT_WIDTH, 2, byte-offset bits dropped from the PC.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- upd_valid  in  1  a branch result is presented this cycle.
- upd_is_cond_br  in  1  the branch is conditional; updates with this low are ignored.
- upd_br_addr  in  PC_WIDTH  address of the branch.
- upd_exec_taken  in  1  resolved direction of the branch.
- upd_global_history  in  GHR_WIDTH  history captured at prediction time.
- upd_pht_prev  in  2  PHT counter value captured at prediction time.
- pht_wr_grant  in  1  the PHT write port is free this cycle.
- pht_we  out  1  PHT write enable.
- pht_wa  out  PHT_INDEX_WIDTH  PHT write address.
- pht_wv  out  2  PHT write value.
- q_count  out  $clog2(QUEUE_SIZE)+1  current occupancy.
- q_full  out  1  occupancy equals QUEUE_SIZE.
- q_empty  out  1  occupancy is 0.
- drop_count  out  16  saturating count of updates dropped on overflow.

Behaviour:
- Accepted update: upd_valid && upd_is_cond_br. Any other input is ignored.
- Index: upd_br_addr[PHT_INDEX_WIDTH+INSN_ADDR_BIT_WIDTH-1 : INSN_ADDR_BIT_WIDTH] XOR upd_global_history, with the history zero-extended and aligned to the LSB.
- New counter value:
  - taken && prev<3 -> prev+1
  - !taken && prev>0 -> prev-1
  - otherwise prev (saturating at 0 and 3).
- Dequeue: pht_we = !q_empty && pht_wr_grant, combinational. pht_wa and pht_wv come from the head entry. When pht_we is high, the head pointer advances at the clock edge.
- Latency: an update accepted at edge t into an empty queue can be written at cycle t+1 at the earliest. There is no same-cycle bypass.
- Tail merge:
  - Condition: the queue is non-empty, the accepted update's index equals the tail entry's index, and the tail entry is not the one being dequeued this cycle (not the case count==1 && pht_we).
  - Effect: the tail value is overwritten with the new counter value. Pointers and count are unchanged. No drop occurs even when the queue is full.
- Enqueue: an accepted update that is not merged is written at the tail, and the tail pointer advances. Pointers wrap modulo QUEUE_SIZE.
- Full and dequeue in the same cycle: a full queue that dequeues in the same cycle still accepts an enqueue. Count stays QUEUE_SIZE.
- Overflow: full, no dequeue and no merge -> the update is dropped. drop_count increments and saturates at 0xFFFF. Queue state is unchanged.
- Count: next count = count + enq - deq, where a merge counts as neither enqueue nor dequeue.
- q_full and q_empty are decoded from the count register.
- Reset values (asynchronous): pointers 0, count 0, q_empty=1, q_full=0, drop_count=0, so pht_we=0. Entry storage is not reset.
- Reset mid-operation discards all pending updates immediately. pht_we drops in the same cycle, without waiting for a clock edge.
- Queue storage may be a register array or LUT RAM with a combinational head read.

Test Plan:
- Single update: addr=0x0000_0104, ghr=0x003, prev=1, taken=1, grant held 1 -> q_count=1 after the edge; next cycle pht_we=1, pht_wa=0x041^0x003=0x042, pht_wv=2; q_empty=1 afterwards.
- Saturation: prev=3 taken -> wv=3; prev=0 not-taken -> wv=0; prev=2 not-taken -> wv=1.
- Merge: grant=0, two consecutive updates to index 0x042 with wv 2 then 3 -> q_count=1; on grant, one write with wv=3.
- Fill and drop: grant=0, 33 distinct indices -> q_full=1 after the 32nd, drop_count=1. A 34th update matching the tail index merges, so drop_count stays 1. Then grant=1 for 32 cycles -> 32 writes in FIFO order, wrap-around correct, q_empty=1.
- Full plus simultaneous enqueue and dequeue: full queue, grant=1 and a new distinct update in the same cycle -> count stays 32, and the new entry is written out last.
- Async reset with 5 entries queued: assert rst between clock edges -> pht_we=0 and q_count=0 immediately; after release, nothing is written until a new update arrives.
